// File: rtl/vote_sampler_pkg.sv
// Shared definitions for the vote front-end and the downstream majority stage.
package vote_sampler_pkg;

    localparam int unsigned NUM_VOTERS = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/vote_sampler_input_debounce.sv
// One voter input: 2-FF synchroniser, counted debounce, and a press pulse on an accepted rise.
module input_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // Counter reaching DEBOUNCE_CYCLES is detected one step early so the
    // level change lands on the cycle the count would hit the threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync2;
                cnt    <= '0;
                press  <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vote_sampler.sv
// Timed vote window: collects debounced first presses per voter and hands the
// vote vector to the majority stage over a valid/ready handshake.
module vote_sampler
    import vote_sampler_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned WINDOW_CYCLES   = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_VOTERS-1:0] vote_raw,
    output logic [NUM_VOTERS-1:0] votes,
    output logic                  votes_valid,
    input  logic                  votes_ready,
    output logic                  busy,
    output logic [NUM_VOTERS-1:0] cast_mask
);

    localparam int unsigned WW = $clog2(WINDOW_CYCLES);

    state_t                  state;
    state_t                  state_next;
    logic [NUM_VOTERS-1:0]   press;
    logic [NUM_VOTERS-1:0]   mask_next;
    logic [WW-1:0]           wcnt;
    logic                    window_end;
    logic                    collect_exit;

    for (genvar i = 0; i < NUM_VOTERS; i++) begin : g_voter
        input_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .raw  (vote_raw[i]),
            .press(press[i])
        );
    end

    always_comb begin
        mask_next    = cast_mask | press;
        window_end   = (wcnt == WW'(WINDOW_CYCLES - 1));
        collect_exit = window_end || (&mask_next);
        state_next   = state;
        case (state)
            IDLE:    if (start)        state_next = COLLECT;
            COLLECT: if (collect_exit) state_next = DONE;
            DONE:    if (votes_ready)  state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // busy/votes_valid are flopped from the next state so they stay pure register outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            votes_valid <= 1'b0;
        end else begin
            state       <= state_next;
            busy        <= (state_next != IDLE);
            votes_valid <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            votes     <= '0;
            cast_mask <= '0;
            wcnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        votes     <= '0;
                        cast_mask <= '0;
                        wcnt      <= '0;
                    end
                end
                COLLECT: begin
                    votes     <= votes | (press & ~cast_mask);
                    cast_mask <= mask_next;
                    if (!collect_exit) wcnt <= wcnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
